// File: rtl/cache_pkg.sv
// Shared constants and refill FSM state type for the instruction-cache refill engine.
package cache_pkg;

    localparam int unsigned BLOCK_WORDS = 16;
    localparam int unsigned SET_BITS    = 6;
    localparam int unsigned ADDR_WIDTH  = 32;
    localparam int unsigned OFFSET_BITS = $clog2(BLOCK_WORDS * 4);
    localparam int unsigned TAG_BITS    = ADDR_WIDTH - SET_BITS - OFFSET_BITS;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        FILL,
        WRITE,
        DRAIN
    } refill_state_t;

endpackage

// File: rtl/refill_line_buf.sv
// Beat counter plus word-indexed line register for a cache refill.
module refill_line_buf #(
    parameter int unsigned BLOCK_WORDS = cache_pkg::BLOCK_WORDS
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      clear,
    input  logic                      beat_valid,
    input  logic                      wr_en,
    input  logic [31:0]               data,
    output logic                      last_beat,
    output logic [BLOCK_WORDS*32-1:0] line
);

    localparam int unsigned CNT_BITS = $clog2(BLOCK_WORDS);

    logic [CNT_BITS-1:0]       count_q;
    logic [BLOCK_WORDS*32-1:0] line_q;

    assign last_beat = beat_valid && (count_q == CNT_BITS'(BLOCK_WORDS - 1));
    assign line      = line_q;

    // Counter wraps naturally to 0 on the last beat.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q <= '0;
        end else if (clear) begin
            count_q <= '0;
        end else if (beat_valid) begin
            count_q <= count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            line_q <= '0;
        end else if (beat_valid && wr_en) begin
            line_q[32*int'(count_q) +: 32] <= data;
        end
    end

endmodule

// File: rtl/instr_cache_refill.sv
// Instruction-cache line refill engine: block read, line assembly, one-cycle line write.
// Optional performance counters are enabled with `define REFILL_PERF_CNT_EN.
module instr_cache_refill #(
    parameter int unsigned BLOCK_WORDS = cache_pkg::BLOCK_WORDS,
    parameter int unsigned SET_BITS    = cache_pkg::SET_BITS,
    parameter int unsigned ADDR_WIDTH  = cache_pkg::ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  CacheMiss,
    input  logic                  CacheRepActive,
    input  logic [ADDR_WIDTH-1:0] PCF,
    input  logic                  Abort,
    output logic                  MemReq,
    output logic [ADDR_WIDTH-1:0] MemAddr,
    input  logic                  MemReqReady,
    input  logic                  MemRdValid,
    input  logic [31:0]           MemRdData,
    output logic                  RefillWrEn,
    output logic [SET_BITS-1:0]   RefillSet,
    output logic [ADDR_WIDTH-SET_BITS-$clog2(BLOCK_WORDS*4)-1:0] RefillTag,
    output logic [BLOCK_WORDS*32-1:0] RefillBlock,
    output logic                  RefillStall,
    output logic                  RefillDone
`ifdef REFILL_PERF_CNT_EN
    ,
    output logic [31:0]           RefillCount,
    output logic [31:0]           StallCycles
`endif
);

    import cache_pkg::*;

    localparam int unsigned OFF_BITS = $clog2(BLOCK_WORDS * 4);
    localparam int unsigned TAG_W    = ADDR_WIDTH - SET_BITS - OFF_BITS;

    refill_state_t                state_q, state_d;
    logic [ADDR_WIDTH-OFF_BITS-1:0] blk_q;
    logic [SET_BITS-1:0]          set_q;
    logic [TAG_W-1:0]             tag_q;
    logic                         start;
    logic                         buf_clear;
    logic                         beat_valid;
    logic                         buf_wr_en;
    logic                         last_beat;
    logic                         unused_pcf_offset;

    assign unused_pcf_offset = ^PCF[OFF_BITS-1:0];

    assign start      = (state_q == IDLE) && CacheMiss && CacheRepActive && !Abort;
    assign buf_clear  = (state_q == REQ) && MemReqReady;
    assign beat_valid = MemRdValid && ((state_q == FILL) || (state_q == DRAIN));
    assign buf_wr_en  = (state_q == FILL);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            blk_q <= '0;
            set_q <= '0;
            tag_q <= '0;
        end else if (start) begin
            blk_q <= PCF[ADDR_WIDTH-1:OFF_BITS];
            set_q <= PCF[OFF_BITS+SET_BITS-1:OFF_BITS];
            tag_q <= PCF[ADDR_WIDTH-1:OFF_BITS+SET_BITS];
        end
    end

    always_comb begin
        state_d     = state_q;
        MemReq      = 1'b0;
        MemAddr     = '0;
        RefillWrEn  = 1'b0;
        RefillDone  = 1'b0;
        RefillStall = 1'b1;
        unique case (state_q)
            IDLE: begin
                RefillStall = start;
                if (start) begin
                    state_d = REQ;
                end
            end
            REQ: begin
                MemReq  = 1'b1;
                MemAddr = {blk_q, {OFF_BITS{1'b0}}};
                if (MemReqReady) begin
                    state_d = Abort ? DRAIN : FILL;
                end else if (Abort) begin
                    state_d = IDLE;
                end
            end
            FILL: begin
                // An abort coinciding with the final beat has nothing left to drain.
                if (last_beat) begin
                    state_d = Abort ? IDLE : WRITE;
                end else if (Abort) begin
                    state_d = DRAIN;
                end
            end
            WRITE: begin
                RefillWrEn = 1'b1;
                RefillDone = 1'b1;
                state_d    = IDLE;
            end
            DRAIN: begin
                if (last_beat) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    refill_line_buf #(
        .BLOCK_WORDS(BLOCK_WORDS)
    ) u_line_buf (
        .clk       (clk),
        .reset     (reset),
        .clear     (buf_clear),
        .beat_valid(beat_valid),
        .wr_en     (buf_wr_en),
        .data      (MemRdData),
        .last_beat (last_beat),
        .line      (RefillBlock)
    );

    assign RefillSet = set_q;
    assign RefillTag = tag_q;

`ifdef REFILL_PERF_CNT_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            RefillCount <= '0;
            StallCycles <= '0;
        end else begin
            if (RefillDone && (RefillCount != '1)) begin
                RefillCount <= RefillCount + 32'd1;
            end
            if (RefillStall && (StallCycles != '1)) begin
                StallCycles <= StallCycles + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_instr_cache_refill.sv
// Self-checking bench for instr_cache_refill: behavioural refill model plus directed and random refills.
module tb_instr_cache_refill;

    localparam int BW = 16;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          CacheMiss = 1'b0;
    logic          CacheRepActive = 1'b0;
    logic [31:0]   PCF = '0;
    logic          Abort = 1'b0;
    logic          MemReq;
    logic [31:0]   MemAddr;
    logic          MemReqReady = 1'b0;
    logic          MemRdValid = 1'b0;
    logic [31:0]   MemRdData = '0;
    logic          RefillWrEn;
    logic [5:0]    RefillSet;
    logic [19:0]   RefillTag;
    logic [511:0]  RefillBlock;
    logic          RefillStall;
    logic          RefillDone;
`ifdef REFILL_PERF_CNT_EN
    logic [31:0]   RefillCount;
    logic [31:0]   StallCycles;
`endif

    instr_cache_refill dut (
        .clk           (clk),
        .reset         (reset),
        .CacheMiss     (CacheMiss),
        .CacheRepActive(CacheRepActive),
        .PCF           (PCF),
        .Abort         (Abort),
        .MemReq        (MemReq),
        .MemAddr       (MemAddr),
        .MemReqReady   (MemReqReady),
        .MemRdValid    (MemRdValid),
        .MemRdData     (MemRdData),
        .RefillWrEn    (RefillWrEn),
        .RefillSet     (RefillSet),
        .RefillTag     (RefillTag),
        .RefillBlock   (RefillBlock),
        .RefillStall   (RefillStall),
        .RefillDone    (RefillDone)
`ifdef REFILL_PERF_CNT_EN
        ,
        .RefillCount   (RefillCount),
        .StallCycles   (StallCycles)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Behavioural model: a request outstanding, a count of beats still owed, whether they are kept.
    bit          m_req = 0;
    int          m_left = 0;
    bit          m_keep = 0;
    bit          m_write = 0;
    logic [31:0] m_addr = '0;
    logic [5:0]  m_set = '0;
    logic [19:0] m_tag = '0;
    logic [31:0] m_words [BW];

    function automatic bit model_busy();
        return m_req || (m_left > 0) || m_write;
    endfunction

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_req = 0; m_left = 0; m_keep = 0; m_write = 0;
        end else if (m_write) begin
            m_write = 0;
        end else if (m_req) begin
            if (MemReqReady) begin
                m_req = 0; m_left = BW; m_keep = !Abort;
            end else if (Abort) begin
                m_req = 0;
            end
        end else if (m_left > 0) begin
            if (MemRdValid) begin
                if (m_keep) m_words[BW - m_left] = MemRdData;
                m_left--;
            end
            if (Abort) m_keep = 0;
            if (m_left == 0 && m_keep) m_write = 1;
        end else if (CacheMiss && CacheRepActive && !Abort) begin
            m_req  = 1;
            m_addr = PCF & ~32'h3F;
            m_set  = 6'((PCF >> 6) & 32'h3F);
            m_tag  = 20'(PCF >> 12);
        end
    end

    bit           go = 0;
    bit           start_e;
    logic [511:0] exp_blk;

    always @(negedge clk) begin
        if (go) begin
            start_e = !model_busy() && CacheMiss && CacheRepActive && !Abort;
            chk("MemReq", MemReq, reset && m_req);
            chk("MemAddr", MemAddr, (reset && m_req) ? m_addr : 32'h0);
            chk("RefillWrEn", RefillWrEn, reset && m_write);
            chk("RefillDone", RefillDone, reset && m_write);
            chk("RefillStall", RefillStall, reset && (model_busy() || start_e));
            if (!reset) begin
                chk("rst_RefillSet", RefillSet, 6'h0);
                chk("rst_RefillTag", RefillTag, 20'h0);
                chk("rst_RefillBlock", RefillBlock, 512'h0);
            end else if (m_write) begin
                for (int i = 0; i < BW; i++) exp_blk[i*32 +: 32] = m_words[i];
                chk("RefillSet", RefillSet, m_set);
                chk("RefillTag", RefillTag, m_tag);
                chk("RefillBlock", RefillBlock, exp_blk);
            end
        end
    end

    // Per-refill observations for hand-computed checks.
    bit           req_log [200];
    bit           stall_log [200];
    int           wr_cnt;
    int           wr_cyc;
    bit           req_any;
    bit           addr_moved;
    bit           rst_quiet;
    logic [31:0]  first_addr;
    logic [5:0]   cap_set;
    logic [511:0] cap_block;

    task automatic refill(input logic [31:0] pcf, input bit rep, input int rdy_dly,
                          input int vmode, input int abort_cyc, input int reset_cyc);
        int pend = 0;
        int req_seen = 0;
        bit hs, beat, done = 0, fin = 0, got_addr = 0;
        wr_cnt = 0; wr_cyc = -1; req_any = 0; addr_moved = 0; rst_quiet = 1;
        first_addr = '0; cap_set = '0; cap_block = '0;
        for (int c = 0; c < 200; c++) begin
            req_log[c] = 0; stall_log[c] = 0;
        end
        for (int cyc = 0; cyc < 200; cyc++) begin
            reset          = (cyc != reset_cyc);
            PCF            = (cyc == 0) ? pcf : $urandom;
            CacheMiss      = (cyc == 0) && reset;
            CacheRepActive = rep;
            Abort          = (cyc == abort_cyc);
            if (!reset) pend = 0;
            MemReqReady    = reset && MemReq && (req_seen >= rdy_dly);
            if (MemReq) req_seen++;
            MemRdValid     = (pend > 0) && ((vmode == 0) || (vmode == 1 && cyc % 2 == 0) ||
                                            (vmode == 2 && $urandom_range(0, 2) != 0));
            MemRdData      = (vmode == 2) ? $urandom : 32'hA000_0000 + 32'(BW - pend);
            @(negedge clk);
            req_log[cyc]   = MemReq;
            stall_log[cyc] = RefillStall;
            if (MemReq) begin
                req_any = 1;
                if (!got_addr) begin first_addr = MemAddr; got_addr = 1; end
                else if (MemAddr !== first_addr) addr_moved = 1;
            end
            if (RefillWrEn) begin
                wr_cnt++; wr_cyc = cyc; cap_set = RefillSet; cap_block = RefillBlock;
            end
            if (!reset && (MemReq || MemAddr != 0 || RefillWrEn || RefillSet != 0 || RefillTag != 0 ||
                           RefillBlock != 0 || RefillStall || RefillDone))
                rst_quiet = 0;
            hs   = MemReq && MemReqReady;
            beat = MemRdValid;
            @(posedge clk); #1;
            if (hs) pend = BW;
            else if (beat && pend > 0) pend--;
            if (done) begin fin = 1; break; end
            done = (cyc > 0) && !model_busy() && (pend == 0) && reset;
        end
        chk("refill_terminates", fin, 1);
        reset = 1; CacheMiss = 0; Abort = 0; MemReqReady = 0; MemRdValid = 0;
    endtask

    initial begin
        logic [31:0] w;
        bit gap;
        repeat (2) @(posedge clk);
        #1 go = 1;
        @(posedge clk); #1 reset = 1;
        @(posedge clk); #1;

        // Reset pulled in mid-fill: quiet outputs, no write afterwards.
        refill(32'h0000_3000, 1, 0, 0, -1, 8);
        chk("rst_outputs_quiet", rst_quiet, 1);
        chk("rst_no_write", wr_cnt, 0);

        // Best-case refill.
        refill(32'h0000_1A44, 1, 0, 0, -1, -1);
        chk("t2_mem_addr", first_addr, 32'h0000_1A40);
        chk("t2_set", cap_set, 6'h29);
        chk("t2_write_cycle", wr_cyc, 18);
        chk("t2_write_once", wr_cnt, 1);
        for (int i = 0; i < BW; i++) begin
            w = cap_block[i*32 +: 32];
            chk("t2_word", w, 32'hA000_0000 + 32'(i));
        end
`ifdef REFILL_PERF_CNT_EN
        chk("perf_refill_count", RefillCount, 32'd1);
`endif

        // Late ready and gappy data.
        refill(32'h0001_2340, 1, 3, 1, -1, -1);
        chk("t3_addr_stable", addr_moved, 0);
        chk("t3_mem_addr", first_addr, 32'h0001_2340);
        chk("t3_write_once", wr_cnt, 1);
        for (int i = 0; i < BW; i++) begin
            w = cap_block[i*32 +: 32];
            chk("t3_word", w, 32'hA000_0000 + 32'(i));
        end
        gap = 0;
        for (int c = 0; c <= wr_cyc; c++) if (!stall_log[c]) gap = 1;
        chk("t3_stall_held", gap, 0);
        if (wr_cyc >= 0) chk("t3_stall_released", stall_log[wr_cyc + 1], 0);

        // Abort in REQ before ready.
        refill(32'h0000_4444, 1, 5, 0, 1, -1);
        chk("t4_req_cycle1", req_log[1], 1);
        chk("t4_req_dropped", req_log[2], 0);
        chk("t4_stall_dropped", stall_log[2], 0);
        chk("t4_no_write", wr_cnt, 0);

        // Abort after five beats: drain the rest.
        refill(32'h0000_8880, 1, 0, 0, 7, -1);
        chk("t5_no_write", wr_cnt, 0);
        chk("t5_drain_stall", stall_log[17], 1);
        chk("t5_idle_after_drain", stall_log[18], 0);

        // Miss without replacement permission.
        refill(32'h0000_5000, 0, 0, 0, -1, -1);
        chk("t6_no_req", req_any, 0);
        chk("t6_no_stall", stall_log[0], 0);

        // Random refills, aborts and timings.
        for (int n = 0; n < 40; n++) begin
            refill($urandom, $urandom_range(0, 5) != 0, $urandom_range(0, 4), 2,
                   ($urandom_range(0, 1) != 0) ? $urandom_range(0, 30) : -1, -1);
        end

        go = 0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/instr_cache_refill.md
# instr_cache_refill

Instruction-cache line refill engine for the pipelined RISC-V core. It sits directly downstream of `instr_cache_ctlr`. When the controller reports a miss while replacement is permitted, this block issues a block-aligned read to instruction memory and collects `BLOCK_WORDS` data beats into a line buffer. It then performs a one-cycle write of the complete line into the addressed set and stalls fetch for the whole refill. A misprediction abort cancels or drains a refill without corrupting the cache.

## Interface
Parameters:
- `BLOCK_WORDS`, 16, 32-bit words per cache line (power of two, ≥2)
- `SET_BITS`, 6, set index width (64 sets)
- `ADDR_WIDTH`, 32, byte address width

Ports:
- `clk`  in  1  core clock; all state changes on rising edge
- `reset`  in  1  asynchronous, active-low reset (asserted at 0)
- `CacheMiss`  in  1  miss indication from `instr_cache_ctlr`
- `CacheRepActive`  in  1  replacement permitted (from `instr_cache_ctlr`)
- `PCF`  in  ADDR_WIDTH  fetch address that missed
- `Abort`  in  1  misprediction flush; discard the refill in progress
- `MemReq`  out  1  read-request valid
- `MemAddr`  out  ADDR_WIDTH  block-aligned request address
- `MemReqReady`  in  1  memory accepts the request
- `MemRdValid`  in  1  read data beat valid
- `MemRdData`  in  32  read data beat
- `RefillWrEn`  out  1  one-cycle line write strobe
- `RefillSet`  out  SET_BITS  target set
- `RefillTag`  out  ADDR_WIDTH-SET_BITS-OFFSET_BITS  tag to store
- `RefillBlock`  out  BLOCK_WORDS*32  assembled line; word i is at bits [32i+31:32i]
- `RefillStall`  out  1  hold fetch stage
- `RefillDone`  out  1  pulse coincident with `RefillWrEn`

## Operation
- Address split: `OFFSET_BITS = log2(BLOCK_WORDS*4)`. Set = `PCF[OFFSET_BITS+SET_BITS-1:OFFSET_BITS]`. Tag = the remaining upper bits.
- Start condition: state is IDLE, `CacheMiss & CacheRepActive` is true, and `Abort` is low.
- States:
  - IDLE: outputs quiet. On the start condition, latch the block-aligned `PCF`, set, and tag, then go to REQ.
  - REQ: drive `MemReq`=1 and hold `MemAddr` stable until `MemReqReady`. On the handshake, clear the beat counter and go to FILL.
  - FILL: each `MemRdValid` writes `MemRdData` into word[count] and increments count. When the beat with count = BLOCK_WORDS-1 arrives, go to WRITE.
  - WRITE: assert `RefillWrEn`=1 and `RefillDone`=1 for exactly one cycle, then go to IDLE.
  - DRAIN: count the remaining beats without writing. On the last beat, go to IDLE.
- `Abort` handling:
  - IDLE: ignored, but it suppresses a start in the same cycle.
  - REQ without handshake that cycle: go to IDLE and drop `MemReq`.
  - REQ with handshake in the same cycle: go to DRAIN.
  - FILL: go to DRAIN. A beat arriving in the abort cycle is still counted.
  - WRITE: ignored; the write completes.
  - DRAIN: no effect.
- `RefillStall` is 1 in every state except IDLE. In IDLE it is combinationally 1 while the start condition is true.
- `RefillSet`, `RefillTag`, and `RefillBlock` hold the latched values and are only meaningful when `RefillWrEn`=1.
- A second miss is not accepted until the block returns to IDLE.

## Timing
- Reset values:
  - all outputs 0
  - state IDLE, count 0
  - line buffer 0
- Cycle 0: miss seen in IDLE. `RefillStall` is 1 combinationally.
- Cycle 1: REQ, `MemReq`=1.
- Best case (ready in cycle 1, one beat per cycle): beats in cycles 2 to BLOCK_WORDS+1, WRITE in cycle BLOCK_WORDS+2, IDLE in cycle BLOCK_WORDS+3. For `BLOCK_WORDS`=16, WRITE is in cycle 18.
- Gaps in `MemRdValid` or `MemReqReady` stretch the refill with no loss of data.
- Reset asserted mid-refill: return to IDLE immediately. No write and no done pulse are produced.
- The beat counter is `log2(BLOCK_WORDS)` bits wide. It wraps to 0 on the last beat.

## Configuration
- `REFILL_PERF_CNT_EN` defined: adds output ports `RefillCount` [31:0] and `StallCycles` [31:0].
  - `RefillCount` increments on each `RefillDone`.
  - `StallCycles` increments on each cycle with `RefillStall`=1.
  - Both saturate at 32'hFFFF_FFFF and reset to 0.
- `REFILL_PERF_CNT_EN` undefined: these ports and the counter logic are absent, with no other behavioural change.

## Structure
- `cache_pkg`:
  - `refill_state_t` enum {IDLE, REQ, FILL, WRITE, DRAIN}
  - `BLOCK_WORDS`, `SET_BITS`, `OFFSET_BITS`, `TAG_BITS` constants
- Sub-module `refill_line_buf`:
  - beat counter plus word-indexed line register
  - inputs: clear, beat-valid, data
  - outputs: last-beat flag, assembled line

## Test plan
- Reset with `reset`=0 in mid-FILL -> all outputs 0, state IDLE. After release, no `RefillWrEn` appears.
- Miss at `PCF`=32'h0000_1A44, ready immediately, 16 consecutive beats with data 32'hA000_0000+i -> `MemAddr`=32'h0000_1A40 and `RefillSet`=6'h29. `RefillBlock` word i = 32'hA000_0000+i. `RefillWrEn` appears in cycle 18 for one cycle.
- `MemReqReady` delayed 3 cycles, and `MemRdValid` deasserted every other cycle -> `MemAddr` stable throughout REQ. The line is still correct, and `RefillStall` stays 1 until the cycle after WRITE.
- `Abort` in REQ before ready -> `MemReq` drops the next cycle and the block returns to IDLE with `RefillStall`=0.
- `Abort` after beat 5 -> DRAIN consumes the remaining 10 beats. No `RefillWrEn`, then IDLE.
- `CacheMiss`=1 with `CacheRepActive`=0 -> no `MemReq`. With `REFILL_PERF_CNT_EN` defined, `RefillCount` is 1 after one full refill.
